ss_deser: RTL and testbench
===========================

SS_DESER -- requirements
Module: ss_deser

Interface
REQ-001 The block SHALL provide parameter SYNC_WORD, default 8'hA5: frame sync pattern searched in the serial stream.
REQ-002 The block SHALL provide parameter FRAME_LEN, default 16: data words per frame, legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port din  input  1  serial data bit from the registered mux stage, MSB first.
REQ-006 The block SHALL have port din_vld  input  1  din qualifier; bits are sampled only on edges where din_vld=1.
REQ-007 The block SHALL have port word_out  output  8  deserialized data word.
REQ-008 The block SHALL have port word_vld  output  1  word_out valid.
REQ-009 The block SHALL have port word_rdy  input  1  consumer ready.
REQ-010 The block SHALL have port locked  output  1  high while in state DATA.
REQ-011 The block SHALL have port ovf  output  1  sticky overflow flag.
REQ-012 The block SHALL have port par_err  output  1  parity error for the word on word_out, qualified by word_vld.

Function
REQ-013 The block SHALL implement a two-state FSM: HUNT and DATA; locked=1 exactly when state=DATA.
REQ-014 In HUNT, each sampled bit SHALL shift into sr[7:0] as sr <= {sr[6:0], din}.
REQ-015 When the post-shift sr value equals SYNC_WORD, the FSM SHALL enter DATA on that edge, with bit and word counters cleared to 0.
REQ-016 Sync word bits SHALL never be delivered as data.
REQ-017 In DATA, sampled bits SHALL assemble into a word MSB first, with a bit counter running 0..BPW-1; BPW=8, or 9 under REQ-029.
REQ-018 The edge that samples a word's final bit SHALL load the word into the output buffer, so word_vld is high from the next cycle: one cycle of latency after the last bit.
REQ-019 A transfer SHALL occur on any edge with word_vld=1 and word_rdy=1; word_vld SHALL clear afterwards unless a new word loads on the same edge.
REQ-020 While word_vld=1 and word_rdy=0, word_out and par_err SHALL hold stable.
REQ-021 On word completion with the buffer full and word_rdy=1: the old word transfers, the new word loads, word_vld stays 1, and ovf is unchanged.
REQ-022 On word completion with the buffer full and word_rdy=0: the new word SHALL be dropped, the buffer kept, and ovf set to 1 and held until reset.
REQ-023 The word counter SHALL be $clog2(FRAME_LEN+1) bits wide and increment per completed word, including dropped words.
REQ-024 After word FRAME_LEN completes, the FSM SHALL return to HUNT with sr cleared to 8'h00; the output buffer is unaffected.
REQ-025 With din_vld=0, the FSM, sr and the counters SHALL hold; the output handshake still operates.

Reset
REQ-026 With reset_n=0 at a clock edge, the block SHALL set state=HUNT, sr=0, counters=0, word_out=0, word_vld=0, locked=0, ovf=0, par_err=0.
REQ-027 Reset asserted mid-word or mid-frame SHALL discard the partial word and any buffered word, with no word_vld pulse.
REQ-028 Reset SHALL take priority over din_vld and word_rdy on the same edge.

Configuration
REQ-029 With macro SS_DESER_PARITY_EN defined, BPW=9: eight data bits followed by one even-parity bit covering data+parity, and par_err loads with the word, set to 1 on mismatch.
REQ-030 Without SS_DESER_PARITY_EN, BPW=8 and par_err SHALL be tied to 0.
REQ-031 The sync search SHALL be 8 bits in both configurations.

Verification
REQ-032 The bench SHALL cover: after reset, stream 0xA5 then 0x3C with word_rdy=1 -> locked=1 after the 8th sync bit, word_out=0x3C with word_vld=1 for one cycle, one cycle after the last bit.
REQ-033 The bench SHALL cover: stream 0xFF then 0xA5 (sync preceded by garbage) -> lock occurs only on the final sync bit, and no word_vld occurs before the first data word.
REQ-034 The bench SHALL cover: word_rdy=0, deliver words 0x11 and 0x22 -> word_out holds 0x11, ovf=1 after 0x22 completes, and raising word_rdy transfers 0x11 only.
REQ-035 The bench SHALL cover: FRAME_LEN=2, sync then words 0x01, 0x02, 0x03 -> locked falls after 0x02, and 0x03 is not delivered.
REQ-036 The bench SHALL cover: reset_n=0 after 4 data bits with a buffered word pending -> all outputs return to 0 next cycle, and a new sync is required to lock again.
REQ-037 The bench SHALL cover, with SS_DESER_PARITY_EN: data 0x07 with parity bit 0 -> par_err=1 with word_vld; data 0x07 with parity bit 1 -> par_err=0.

Source files
------------

// File: rtl/ss_deser.sv
// Serial-to-parallel deserializer: hunts for an 8-bit sync pattern, then assembles
// FRAME_LEN words into a one-deep output buffer. Build option SS_DESER_PARITY_EN adds an even-parity bit per word.
module ss_deser #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  input  logic       din_vld,
  output logic [7:0] word_out,
  output logic       word_vld,
  input  logic       word_rdy,
  output logic       locked,
  output logic       ovf,
  output logic       par_err
);

`ifdef SS_DESER_PARITY_EN
  localparam int unsigned BPW = 9;
`else
  localparam int unsigned BPW = 8;
`endif
  localparam int unsigned BCW = 4;
  localparam int unsigned WCW = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t         state;
  logic [7:0]     sr;
  logic [BCW-1:0] bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic [BPW-2:0] acc;

  logic [7:0]     sr_shift;
  logic [BPW-1:0] word_full;
  logic [7:0]     word_data;
  logic           word_par_err;
  logic           sync_hit;
  logic           last_bit;
  logic           word_done;
  logic           frame_end;
  logic           buf_free;

  // Shift candidates and per-edge events, all qualified by din_vld
  assign sr_shift  = {sr[6:0], din};
  assign word_full = {acc, din};
  assign word_data = word_full[BPW-1 -: 8];
  assign sync_hit  = din_vld && (state == HUNT) && (sr_shift == SYNC_WORD);
  assign last_bit  = (bit_cnt == BCW'(BPW - 1));
  assign word_done = din_vld && (state == DATA) && last_bit;
  assign frame_end = (word_cnt == WCW'(FRAME_LEN - 1));
  assign buf_free  = !word_vld || word_rdy;

`ifdef SS_DESER_PARITY_EN
  // Even parity over data plus parity bit: any odd total is an error
  assign word_par_err = ^word_full;
`else
  assign word_par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= HUNT;
      locked   <= 1'b0;
      sr       <= 8'h00;
      bit_cnt  <= '0;
      word_cnt <= '0;
      acc      <= '0;
      word_out <= 8'h00;
      word_vld <= 1'b0;
      par_err  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (din_vld) begin
        case (state)
          HUNT: begin
            sr <= sr_shift;
            if (sync_hit) begin
              state    <= DATA;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              word_cnt <= '0;
            end
          end
          DATA: begin
            acc <= word_full[BPW-2:0];
            if (last_bit) begin
              bit_cnt <= '0;
              if (frame_end) begin
                state    <= HUNT;
                locked   <= 1'b0;
                sr       <= 8'h00;
                word_cnt <= '0;
              end else begin
                word_cnt <= word_cnt + WCW'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end

      // One-deep output buffer: load wins over the transfer clear
      if (word_done && buf_free) begin
        word_out <= word_data;
        par_err  <= word_par_err;
        word_vld <= 1'b1;
      end else if (word_vld && word_rdy) begin
        word_vld <= 1'b0;
      end

      if (word_done && !buf_free) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ss_deser.sv
// Testbench for ss_deser: table-driven frame plus hand-written corner sequences,
// with a scoreboard queue checked against every word transfer.
module tb_ss_deser;

`ifdef SS_DESER_PARITY_EN
  localparam int BPW = 9;
`else
  localparam int BPW = 8;
`endif

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic       exp_locked;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       din;
  logic       din_vld;
  logic       word_rdy;
  logic [7:0] word_out;
  logic       word_vld;
  logic       locked;
  logic       ovf;
  logic       par_err;
  logic [7:0] word_out2;
  logic       word_vld2;
  logic       locked2;
  logic       ovf2;
  logic       par_err2;

  exp_t sb[$];
  vec_t tbl[16];
  int   n_vec;
  int   n_err;
  int   vld2_cnt;
  bit   mon_en;

  ss_deser u_dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_vld(din_vld),
    .word_out(word_out), .word_vld(word_vld), .word_rdy(word_rdy),
    .locked(locked), .ovf(ovf), .par_err(par_err)
  );

  ss_deser #(.SYNC_WORD(8'hA5), .FRAME_LEN(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .din(din), .din_vld(din_vld),
    .word_out(word_out2), .word_vld(word_vld2), .word_rdy(word_rdy),
    .locked(locked2), .ovf(ovf2), .par_err(par_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard sample on the falling edge, then return just after the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (word_vld2 === 1'b1) vld2_cnt++;
    if (mon_en && word_vld === 1'b1 && word_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got word 0x%0h, want no transfer", word_out);
      end else begin
        e = sb.pop_front();
        chk("sb_word", 32'(word_out), 32'(e.d));
        chk("sb_par", 32'(par_err), 32'(e.p));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    din_vld = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic send_bit(input logic b);
    din     = b;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask

  function automatic logic [8:0] mk(input logic [7:0] d);
`ifdef SS_DESER_PARITY_EN
    return {d, ^d};
`else
    return {1'b0, d};
`endif
  endfunction

  // Sends bits first..last of a BPW-bit frame, MSB first
  task automatic send_bits(input logic [8:0] f, input int first, input int last);
    for (int k = first; k <= last; k++) send_bit(f[BPW-1-k]);
  endtask

  task automatic send_word(input logic [7:0] d);
    send_bits(mk(d), 0, BPW - 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  initial begin
    logic [7:0] sync;
    logic [8:0] f;
    int         v0;
    int         early_lock;

    sync     = 8'hA5;
    n_vec    = 0;
    n_err    = 0;
    vld2_cnt = 0;
    mon_en   = 1'b1;
    reset_n  = 1'b0;
    din      = 1'b0;
    din_vld  = 1'b0;
    word_rdy = 1'b0;

    tbl[0]  = '{8'h00, 0, 1'b1};  tbl[1]  = '{8'hFF, 1, 1'b1};
    tbl[2]  = '{8'h55, 0, 1'b1};  tbl[3]  = '{8'hAA, 2, 1'b1};
    tbl[4]  = '{8'h3C, 0, 1'b1};  tbl[5]  = '{8'hC3, 3, 1'b1};
    tbl[6]  = '{8'h80, 0, 1'b1};  tbl[7]  = '{8'h01, 1, 1'b1};
    tbl[8]  = '{8'h7E, 0, 1'b1};  tbl[9]  = '{8'hA5, 2, 1'b1};
    tbl[10] = '{8'h5A, 0, 1'b1};  tbl[11] = '{8'h0F, 0, 1'b1};
    tbl[12] = '{8'hF0, 1, 1'b1};  tbl[13] = '{8'h96, 0, 1'b1};
    tbl[14] = '{8'h69, 3, 1'b1};  tbl[15] = '{8'h42, 0, 1'b0};

    // Reset values, then sync 0xA5 and data 0x3C with consumer ready
    do_reset();
    word_rdy = 1'b1;
    chk("rst_word_out", 32'(word_out), 32'h0);
    chk("rst_word_vld", 32'(word_vld), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_par_err", 32'(par_err), 32'h0);
    for (int i = 7; i >= 1; i--) send_bit(sync[i]);
    chk("lock_before_8th", 32'(locked), 32'h0);
    send_bit(sync[0]);
    chk("lock_after_8th", 32'(locked), 32'h1);
    push(8'h3C, 1'b0);
    send_word(8'h3C);
    chk("w3c_vld", 32'(word_vld), 32'h1);
    chk("w3c_out", 32'(word_out), 32'h3C);
    tick();
    chk("w3c_vld_one_cycle", 32'(word_vld), 32'h0);

    // Garbage before sync, then a full frame from the table with din_vld gaps mid-word
    do_reset();
    word_rdy   = 1'b1;
    early_lock = 0;
    send_byte(8'hFF);
    for (int i = 7; i >= 1; i--) begin
      send_bit(sync[i]);
      if (locked !== 1'b0 || word_vld !== 1'b0) early_lock++;
    end
    chk("no_early_lock_or_word", 32'(early_lock), 32'h0);
    send_bit(sync[0]);
    chk("garbage_lock", 32'(locked), 32'h1);
    for (int i = 0; i < 16; i++) begin
      f = mk(tbl[i].data);
      push(tbl[i].data, 1'b0);
      send_bits(f, 0, 3);
      for (int g = 0; g < tbl[i].gap; g++) begin
        din = ~din;
        tick();
      end
      send_bits(f, 4, BPW - 1);
      chk("tbl_vld", 32'(word_vld), 32'h1);
      chk("tbl_locked", 32'(locked), 32'(tbl[i].exp_locked));
    end
    tick();
    send_word(8'h3C);
    tick();
    chk("post_frame_unlocked", 32'(locked), 32'h0);
    chk("tbl_sb_drained", 32'(sb.size()), 32'h0);

    // Buffer full at completion with consumer ready: swap, no overflow
    do_reset();
    word_rdy = 1'b0;
    send_byte(sync);
    push(8'h11, 1'b0);
    send_word(8'h11);
    chk("swap_first_out", 32'(word_out), 32'h11);
    send_bits(mk(8'h22), 0, BPW - 2);
    push(8'h22, 1'b0);
    word_rdy = 1'b1;
    send_bits(mk(8'h22), BPW - 1, BPW - 1);
    chk("swap_vld", 32'(word_vld), 32'h1);
    chk("swap_out", 32'(word_out), 32'h22);
    chk("swap_no_ovf", 32'(ovf), 32'h0);
    tick();
    chk("swap_drained", 32'(word_vld), 32'h0);

    // Buffer full at completion with consumer stalled: drop and sticky ovf
    do_reset();
    word_rdy = 1'b0;
    send_byte(sync);
    send_word(8'h11);
    chk("ovf_first_clear", 32'(ovf), 32'h0);
    send_word(8'h22);
    chk("ovf_hold_out", 32'(word_out), 32'h11);
    chk("ovf_hold_vld", 32'(word_vld), 32'h1);
    chk("ovf_set", 32'(ovf), 32'h1);
    push(8'h11, 1'b0);
    word_rdy = 1'b1;
    tick();
    chk("ovf_xfer_clear", 32'(word_vld), 32'h0);
    repeat (4) tick();
    chk("ovf_sticky", 32'(ovf), 32'h1);
    chk("ovf_sb_drained", 32'(sb.size()), 32'h0);

    // Short frame on the FRAME_LEN=2 instance: third word is not delivered
    mon_en = 1'b0;
    do_reset();
    word_rdy = 1'b1;
    send_byte(sync);
    chk("f2_locked", 32'(locked2), 32'h1);
    send_word(8'h01);
    chk("f2_w1_vld", 32'(word_vld2), 32'h1);
    chk("f2_w1_out", 32'(word_out2), 32'h01);
    chk("f2_w1_par", 32'(par_err2), 32'h0);
    send_word(8'h02);
    chk("f2_w2_out", 32'(word_out2), 32'h02);
    chk("f2_w2_vld", 32'(word_vld2), 32'h1);
    chk("f2_unlock", 32'(locked2), 32'h0);
    tick();
    v0 = vld2_cnt;
    send_word(8'h03);
    repeat (2) tick();
    chk("f2_no_w3", 32'(vld2_cnt - v0), 32'h0);
    chk("f2_still_hunt", 32'(locked2), 32'h0);
    chk("f2_ovf", 32'(ovf2), 32'h0);
    mon_en = 1'b1;

    // Reset mid-word with a buffered word pending
    do_reset();
    word_rdy = 1'b0;
    send_byte(sync);
    send_word(8'h11);
    chk("mid_pending_vld", 32'(word_vld), 32'h1);
    send_bits(mk(8'h22), 0, 3);
    reset_n = 1'b0;
    din     = 1'b1;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    chk("mid_rst_out", 32'(word_out), 32'h0);
    chk("mid_rst_vld", 32'(word_vld), 32'h0);
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_ovf", 32'(ovf), 32'h0);
    chk("mid_rst_par", 32'(par_err), 32'h0);
    reset_n  = 1'b1;
    word_rdy = 1'b1;
    send_word(8'h22);
    tick();
    chk("mid_needs_sync", 32'(locked), 32'h0);
    send_byte(sync);
    chk("mid_relock", 32'(locked), 32'h1);
    push(8'h3C, 1'b0);
    send_word(8'h3C);
    chk("mid_new_word", 32'(word_out), 32'h3C);
    tick();

`ifdef SS_DESER_PARITY_EN
    // Parity: 0x07 has three ones, so parity bit 0 is an error and 1 is clean
    do_reset();
    word_rdy = 1'b1;
    send_byte(sync);
    push(8'h07, 1'b1);
    send_bits({8'h07, 1'b0}, 0, 8);
    chk("par_bad_vld", 32'(word_vld), 32'h1);
    chk("par_bad_err", 32'(par_err), 32'h1);
    tick();
    push(8'h07, 1'b0);
    send_bits({8'h07, 1'b1}, 0, 8);
    chk("par_good_err", 32'(par_err), 32'h0);
    tick();
`endif

    chk("final_sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
